// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes and fetch-path types
// for the instruction fetch front end.
package cpu_pkg;

  localparam int INST_W = 16;
  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] PC_INC = 16'd2;
  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic [1:0] {
    FS_FETCH,
    FS_WAIT_SPACE,
    FS_STOP,
    FS_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_ent_t;

  function automatic logic is_hlt(input logic [INST_W-1:0] w);
    return w[INST_W-1 -: 4] == OPC_HLT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular prefetch buffer of {inst, pc}
// with push, pop, flush and occupancy count.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_ent_t             push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_ent_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_ent_t mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC, single-outstanding imem requests, prefetch queue.
// FETCH_PERF_CNT_EN adds stall_cnt/drop_cnt counter ports.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pcs,
  input  logic              inst_ready,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state, state_d;
  logic [ADDR_W-1:0] fetch_pc, pc_d, addr_d;
  logic              drop, drop_d, req_d;
  logic              stop_d, issue;
  logic [CW-1:0]     cnt, cnt_d;
  logic              ack_v, redir, pop, push, hlt_pop, empty;
  fetch_ent_t        head, push_data;

  assign ack_v   = imem_ack & imem_req;
  assign redir   = redirect & ~halted;
  assign pop     = inst_valid & inst_ready;
  assign push    = ack_v & ~drop & ~redir;
  assign hlt_pop = pop & ~redir & is_hlt(head.inst);
  assign halted  = (state == FS_HALT);

  assign push_data = '{inst: imem_data, pc: fetch_pc};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redir),
    .head      (head),
    .count     (cnt),
    .empty     (empty)
  );

  assign inst_valid = ~empty & ~halted;
  assign inst       = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc : '0;
  assign inst_pcs   = inst_valid ? head.pc + PC_INC : '0;

  always_comb begin
    pc_d   = fetch_pc;
    drop_d = drop;
    req_d  = imem_req & ~ack_v;
    addr_d = imem_addr;
    stop_d = (state == FS_STOP);
    cnt_d  = cnt + CW'(push) - CW'(pop);
    if (push) begin
      pc_d = fetch_pc + PC_INC;
      if (is_hlt(imem_data)) begin
        stop_d = 1'b1;
      end
    end
    if (ack_v) begin
      drop_d = 1'b0;
    end
    // An in-flight request cannot be cancelled; its data is dropped later.
    if (redir) begin
      pc_d   = redirect_pc & ~ADDR_W'(1);
      stop_d = 1'b0;
      cnt_d  = '0;
      if (imem_req && !imem_ack) begin
        drop_d = 1'b1;
      end
    end
    issue = ~req_d & ~stop_d & ~hlt_pop & ~halted
          & (cnt_d < CW'(DEPTH));
    if (issue) begin
      req_d  = 1'b1;
      addr_d = pc_d;
    end
    if (halted || hlt_pop) begin
      state_d = FS_HALT;
    end else if (stop_d) begin
      state_d = FS_STOP;
    end else if (req_d) begin
      state_d = FS_FETCH;
    end else begin
      state_d = FS_WAIT_SPACE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FS_FETCH;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      drop      <= 1'b0;
    end else begin
      state     <= state_d;
      fetch_pc  <= pc_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
      drop      <= drop_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic discard;
  assign discard = ack_v & (drop | redir);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (!inst_valid && !halted && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (discard && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
